// File: rtl/jp_ctrl_pkg.sv
// rtl/jp_ctrl_pkg.sv - shared register addresses and poll FSM encoding for jp_ctrl
package jp_ctrl_pkg;

    localparam logic [15:0] JP_REG1     = 16'h4016;
    localparam logic [15:0] JP_REG2     = 16'h4017;
    localparam int unsigned NUM_BUTTONS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SAMPLE,
        ST_CLK_HI,
        ST_CLK_LO
    } jp_state_e;

endpackage

// File: rtl/jp_shift.sv
// rtl/jp_shift.sv - 8-bit parallel-load register shifting right with 1 fill
module jp_shift
    import jp_ctrl_pkg::*;
(
    input  logic                   clk_in,
    input  logic                   nrst_in,
    input  logic                   load_i,
    input  logic [NUM_BUTTONS-1:0] data_i,
    input  logic                   shift_i,
    output logic                   bit_o
);

    logic [NUM_BUTTONS-1:0] sh_q;
    logic [NUM_BUTTONS-1:0] sh_d;

    // Load wins over shift; exhausted reads see released (1) buttons.
    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = data_i;
        end else if (shift_i) begin
            sh_d = {1'b1, sh_q[NUM_BUTTONS-1:1]};
        end
    end

    // Shift register state.
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            sh_q <= '1;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign bit_o = sh_q[0];

endmodule

// File: rtl/jp_ctrl.sv
// rtl/jp_ctrl.sv - NES joypad poller with $4016/$4017 CPU read-out
module jp_ctrl
    import jp_ctrl_pkg::*;
#(
    parameter int unsigned POLL_CYCLES = 833333,
    parameter int unsigned HALF_CYCLES = 300
) (
    input  logic        clk_in,
    input  logic        nrst_in,
    input  logic [15:0] a_in,
    input  logic [7:0]  d_in,
    input  logic        wr_in,
    input  logic        rd_in,
    output logic [7:0]  d_out,
    input  logic        jp_data1_in,
    input  logic        jp_data2_in,
    output logic        jp_clk,
    output logic        jp_latch
);

    localparam int unsigned POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int unsigned HALF_W = $clog2(HALF_CYCLES + 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYCLES - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_CYCLES - 1);

    jp_state_e   state_q;
    logic [POLL_W-1:0] poll_q;
    logic [POLL_W-1:0] poll_d;
    logic [HALF_W-1:0] half_q;
    logic [2:0]  idx_q;
    logic [7:0]  stage1_q, stage2_q;
    logic [7:0]  btn1_q, btn2_q;
    logic        jp_clk_q, jp_latch_q;
    logic [1:0]  sync1_q, sync2_q;
    logic        strobe_q;
    logic        poll_wrap;
    logic        sel1, sel2;
    logic        shift1, shift2;
    logic        sh1_bit, sh2_bit;
    logic        unused_d;

    assign poll_wrap = (poll_q == POLL_LAST);
    assign poll_d    = poll_wrap ? '0 : poll_q + 1'b1;
    assign sel1      = (a_in == JP_REG1);
    assign sel2      = (a_in == JP_REG2);
    assign unused_d  = ^d_in[7:1];

    // Pad data is asynchronous to clk_in; two flops before it is sampled.
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            sync1_q <= {sync1_q[0], jp_data1_in};
            sync2_q <= {sync2_q[0], jp_data2_in};
        end
    end

    // Poll sequencer: latch pulse, then 8 samples separated by 7 clock pulses.
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            state_q    <= ST_IDLE;
            poll_q     <= '0;
            half_q     <= '0;
            idx_q      <= '0;
            stage1_q   <= '0;
            stage2_q   <= '0;
            btn1_q     <= '0;
            btn2_q     <= '0;
            jp_clk_q   <= 1'b0;
            jp_latch_q <= 1'b0;
        end else begin
            poll_q <= poll_d;
            case (state_q)
                ST_IDLE: begin
                    if (poll_wrap) begin
                        state_q    <= ST_LATCH;
                        jp_latch_q <= 1'b1;
                        half_q     <= '0;
                    end
                end
                ST_LATCH: begin
                    if (half_q == HALF_LAST) begin
                        state_q    <= ST_SAMPLE;
                        jp_latch_q <= 1'b0;
                        idx_q      <= '0;
                    end else begin
                        half_q <= half_q + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    stage1_q[idx_q] <= ~sync1_q[1];
                    stage2_q[idx_q] <= ~sync2_q[1];
                    if (idx_q == 3'd7) begin
                        // Publish both pads together, including the bit sampled now.
                        btn1_q  <= {~sync1_q[1], stage1_q[6:0]};
                        btn2_q  <= {~sync2_q[1], stage2_q[6:0]};
                        state_q <= ST_IDLE;
                    end else begin
                        state_q  <= ST_CLK_HI;
                        jp_clk_q <= 1'b1;
                        half_q   <= '0;
                    end
                end
                ST_CLK_HI: begin
                    if (half_q == HALF_LAST) begin
                        state_q  <= ST_CLK_LO;
                        jp_clk_q <= 1'b0;
                        half_q   <= '0;
                    end else begin
                        half_q <= half_q + 1'b1;
                    end
                end
                ST_CLK_LO: begin
                    if (half_q == HALF_LAST) begin
                        state_q <= ST_SAMPLE;
                        idx_q   <= idx_q + 3'd1;
                    end else begin
                        half_q <= half_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    jp_clk_q   <= 1'b0;
                    jp_latch_q <= 1'b0;
                end
            endcase
        end
    end

    // Strobe register; writes to $4017 are ignored.
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            strobe_q <= 1'b0;
        end else if (wr_in && sel1) begin
            strobe_q <= d_in[0];
        end
    end

    // A read shifts only outside strobe and only when no write shares the cycle.
    always_comb begin
        shift1 = rd_in && sel1 && !wr_in && !strobe_q;
        shift2 = rd_in && sel2 && !wr_in && !strobe_q;
    end

    jp_shift u_sh1 (
        .clk_in  (clk_in),
        .nrst_in (nrst_in),
        .load_i  (strobe_q),
        .data_i  (btn1_q),
        .shift_i (shift1),
        .bit_o   (sh1_bit)
    );

    jp_shift u_sh2 (
        .clk_in  (clk_in),
        .nrst_in (nrst_in),
        .load_i  (strobe_q),
        .data_i  (btn2_q),
        .shift_i (shift2),
        .bit_o   (sh2_bit)
    );

    // Read mux drives zero when not selected so it can be OR-ed onto the bus.
    always_comb begin
        d_out = 8'h00;
        if (rd_in && sel1) begin
            d_out = {7'b0, sh1_bit};
        end else if (rd_in && sel2) begin
            d_out = {7'b0, sh2_bit};
        end
    end

    assign jp_clk   = jp_clk_q;
    assign jp_latch = jp_latch_q;

endmodule

// File: tb/tb_jp_ctrl.sv
// tb/tb_jp_ctrl.sv - self-checking bench for jp_ctrl
module tb_jp_ctrl;

    localparam int POLL = 64;
    localparam int HALF = 2;
    localparam logic [15:0] JP1 = 16'h4016;
    localparam logic [15:0] JP2 = 16'h4017;

    typedef struct {
        logic [15:0] a;
        logic        rd;
        logic        wr;
        logic [7:0]  d;
        logic [7:0]  exp;
    } vec_t;

    logic        clk_in = 1'b0;
    logic        nrst_in = 1'b0;
    logic [15:0] a_in = 16'h0000;
    logic [7:0]  d_in = 8'h00;
    logic        wr_in = 1'b0;
    logic        rd_in = 1'b0;
    logic [7:0]  d_out;
    logic        jp_data1_in, jp_data2_in;
    logic        jp_clk, jp_latch;

    logic [7:0]  pat1 = 8'b0000_1001;
    logic [7:0]  pat2 = 8'b1000_0000;
    logic [7:0]  sreg1 = 8'h00;
    logic [7:0]  sreg2 = 8'h00;

    int          errors = 0;
    int          checks = 0;
    vec_t        vecs[$];
    logic [7:0]  exp_q[$];

    jp_ctrl #(.POLL_CYCLES(POLL), .HALF_CYCLES(HALF)) dut (
        .clk_in      (clk_in),
        .nrst_in     (nrst_in),
        .a_in        (a_in),
        .d_in        (d_in),
        .wr_in       (wr_in),
        .rd_in       (rd_in),
        .d_out       (d_out),
        .jp_data1_in (jp_data1_in),
        .jp_data2_in (jp_data2_in),
        .jp_clk      (jp_clk),
        .jp_latch    (jp_latch)
    );

    always #5 clk_in = ~clk_in;

    // 4021-style pad: transparent while latched, shifts on rising jp_clk.
    always @(negedge jp_latch) begin
        sreg1 = pat1;
        sreg2 = pat2;
    end
    always @(posedge jp_clk) begin
        sreg1 = {1'b0, sreg1[7:1]};
        sreg2 = {1'b0, sreg2[7:1]};
    end
    assign jp_data1_in = jp_latch ? ~pat1[0] : ~sreg1[0];
    assign jp_data2_in = jp_latch ? ~pat2[0] : ~sreg2[0];

    initial begin
        #100000;
        $display("FAIL watchdog: time=%0t limit reached", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] mbit(input logic [7:0] p, input int i);
        return (i < 8) ? {7'b0, p[i]} : 8'h01;
    endfunction

    function automatic void add(input logic [15:0] a, input logic rd, input logic wr,
                                input logic [7:0] d, input logic [7:0] e);
        vec_t v;
        v.a = a; v.rd = rd; v.wr = wr; v.d = d; v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic step(input vec_t v, input string name);
        logic [7:0] e;
        @(negedge clk_in);
        a_in = v.a; rd_in = v.rd; wr_in = v.wr; d_in = v.d;
        exp_q.push_back(v.exp);
        #2;
        e = exp_q.pop_front();
        check(name, {24'b0, d_out}, {24'b0, e});
        @(posedge clk_in);
        #1;
        rd_in = 1'b0;
        wr_in = 1'b0;
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("%s[%0d]", tag, i));
        end
        vecs.delete();
    endtask

    task automatic wait_latch(output int n);
        n = 0;
        while (jp_latch !== 1'b1 && n < 300) begin
            @(posedge clk_in);
            #1;
            n++;
        end
        if (n >= 300) check("latch_timeout", {31'b0, jp_latch}, 32'd1);
    endtask

    initial begin
        int   n;
        int   lat_hi, lat_rise, clk_rise, run, gap, bad_hi, bad_lo, rises;
        logic prev_l, prev_c, l, c;

        repeat (3) @(posedge clk_in);
        #1;
        check("rst_jp_clk", {31'b0, jp_clk}, 32'd0);
        check("rst_jp_latch", {31'b0, jp_latch}, 32'd0);
        check("rst_d_out", {24'b0, d_out}, 32'd0);
        @(negedge clk_in);
        nrst_in = 1'b1;

        // sh1 resets to all released, btn1 to nothing pressed.
        add(JP1, 1, 0, 0, 8'h01);
        add(JP1, 0, 1, 1, 8'h00);
        add(JP1, 0, 1, 0, 8'h00);
        add(JP1, 1, 0, 0, 8'h00);
        run_vecs("reset_regs");

        // One full poll: latch and clock pulse shape.
        wait_latch(n);
        lat_hi = 0; lat_rise = 0; clk_rise = 0; run = 0; gap = 0;
        bad_hi = 0; bad_lo = 0; prev_l = 1'b0; prev_c = 1'b0;
        for (int i = 0; i < 50; i++) begin
            l = jp_latch;
            c = jp_clk;
            if (l) lat_hi++;
            if (l && !prev_l) lat_rise++;
            if (c && !prev_c) begin
                clk_rise++;
                if (clk_rise > 1 && gap != HALF + 1) bad_lo++;
                run = 0;
            end
            if (c) run++;
            if (!c && prev_c) begin
                if (run != HALF) bad_hi++;
                gap = 0;
            end
            if (!c) gap++;
            prev_l = l;
            prev_c = c;
            @(posedge clk_in);
            #1;
        end
        check("latch_high_cycles", lat_hi, HALF);
        check("latch_pulses", lat_rise, 1);
        check("clk_pulses", clk_rise, 7);
        check("clk_high_width_bad", bad_hi, 0);
        check("clk_low_gap_bad", bad_lo, 0);

        // Strobe, then pad 2 and pad 1 read-out, deselect, ignored $4017 write.
        add(JP1, 0, 1, 1, 8'h00);
        add(JP1, 0, 1, 0, 8'h00);
        for (int i = 0; i < 9; i++) add(JP2, 1, 0, 0, mbit(pat2, i));
        for (int i = 0; i < 9; i++) add(JP1, 1, 0, 0, mbit(pat1, i));
        add(JP1, 0, 0, 0, 8'h00);
        add(16'h4015, 1, 0, 0, 8'h00);
        add(JP2, 0, 1, 1, 8'h00);
        add(JP2, 1, 0, 0, 8'h01);
        // Reads during strobe do not shift; write+read on one cycle does not shift.
        add(JP1, 0, 1, 1, 8'h00);
        for (int i = 0; i < 3; i++) add(JP1, 1, 0, 0, mbit(pat1, 0));
        add(JP1, 0, 1, 0, 8'h00);
        for (int i = 0; i < 3; i++) add(JP1, 1, 0, 0, mbit(pat1, i));
        add(JP1, 1, 1, 0, mbit(pat1, 3));
        add(JP1, 1, 0, 0, mbit(pat1, 3));
        add(JP1, 1, 0, 0, mbit(pat1, 4));
        run_vecs("readout");

        // New pattern polled with strobe low; a mid-poll change must not leak in.
        pat1 = 8'b0110_0111;
        wait_latch(n);
        repeat (10) @(posedge clk_in);
        pat1 = 8'hFF;
        repeat (45) @(posedge clk_in);
        #1;
        add(JP1, 1, 0, 0, mbit(8'b0000_1001, 5));
        add(JP1, 0, 1, 1, 8'h00);
        add(JP1, 0, 1, 0, 8'h00);
        for (int i = 0; i < 9; i++) add(JP1, 1, 0, 0, mbit(8'b0110_0111, i));
        run_vecs("repoll");

        // Reset release to first latch, then abort during bit 4 clock pulse.
        @(negedge clk_in);
        nrst_in = 1'b0;
        @(negedge clk_in);
        nrst_in = 1'b1;
        wait_latch(n);
        check("first_poll_delay", n, POLL);
        rises = 0; prev_c = jp_clk; n = 0;
        while (rises < 5 && n < 200) begin
            @(posedge clk_in);
            #1;
            n++;
            if (jp_clk && !prev_c) rises++;
            prev_c = jp_clk;
        end
        check("bit4_clk_pulses", rises, 5);
        check("bit4_clk_high", {31'b0, jp_clk}, 32'd1);
        #2;
        nrst_in = 1'b0;
        #1;
        check("abort_jp_clk", {31'b0, jp_clk}, 32'd0);
        check("abort_jp_latch", {31'b0, jp_latch}, 32'd0);
        @(negedge clk_in);
        nrst_in = 1'b1;
        wait_latch(n);
        check("restart_delay", n, POLL);
        add(JP1, 0, 1, 1, 8'h00);
        add(JP1, 0, 1, 0, 8'h00);
        add(JP1, 1, 0, 0, 8'h00);
        add(JP1, 1, 0, 0, 8'h00);
        run_vecs("btn_after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jp_ctrl.md
JP_CTRL -- requirements
Module: jp_ctrl

Interface
REQ-001 Parameter POLL_CYCLES, default 833333, clk_in cycles from one poll start to the next (60 Hz at 50 MHz).
REQ-002 Parameter HALF_CYCLES, default 300, width in clk_in cycles of each jp_latch high phase, jp_clk high phase and jp_clk low phase.
REQ-003 Port clk_in  input  1  system clock, 50 MHz.
REQ-004 Port nrst_in  input  1  reset, asynchronous, active-low.
REQ-005 Port a_in  input  16  CPU address bus.
REQ-006 Port d_in  input  8  CPU write data.
REQ-007 Port wr_in  input  1  single-cycle CPU write strobe.
REQ-008 Port rd_in  input  1  single-cycle CPU read strobe.
REQ-009 Port d_out  output  8  CPU read data; 0 when not selected (wired-OR bus).
REQ-010 Port jp_data1_in  input  1  pad 1 serial data, active-low (0 = pressed).
REQ-011 Port jp_data2_in  input  1  pad 2 serial data, active-low (0 = pressed).
REQ-012 Port jp_clk  output  1  pad shift clock.
REQ-013 Port jp_latch  output  1  pad parallel-load latch.

Function
REQ-014 Poll FSM states: IDLE, LATCH, SAMPLE, CLK_HI, CLK_LO; poll counter free-runs modulo POLL_CYCLES and starts a poll (IDLE->LATCH) on wrap to 0.
REQ-015 LATCH: jp_latch=1 for HALF_CYCLES cycles, then SAMPLE with bit index 0.
REQ-016 SAMPLE (1 cycle): stage bit[index] <= ~jp_data1_in (pad 1) and ~jp_data2_in (pad 2) after a two-flop synchronizer; index 7 -> IDLE, else CLK_HI.
REQ-017 CLK_HI: jp_clk=1 for HALF_CYCLES; CLK_LO: jp_clk=0 for HALF_CYCLES, index+1, then SAMPLE.
REQ-018 Bit order: index 0..7 = A, B, Select, Start, Up, Down, Left, Right; stored value 1 = pressed.
REQ-019 On the cycle SAMPLE completes index 7, both 8-bit staging registers copy atomically into btn1/btn2; partial polls never reach btn1/btn2.
REQ-020 Select: $4016 = a_in 16'h4016, $4017 = 16'h4017.
REQ-021 wr_in at $4016: strobe <= d_in[0]; wr_in at $4017 ignored.
REQ-022 While strobe=1, sh1/sh2 reload from btn1/btn2 every cycle.
REQ-023 rd_in at $4016: d_out = {7'b0, sh1[0]}; at $4017: d_out = {7'b0, sh2[0]}; combinational on a_in.
REQ-024 With strobe=0, rd_in at $4016 shifts sh1 right one place with 1 fill (likewise $4017/sh2) on the clock edge ending the strobe cycle; reads 9+ return 1.
REQ-025 d_out = 0 whenever rd_in=0 or a_in is neither address.
REQ-026 rd_in and wr_in on the same cycle: write takes effect, no shift.
REQ-027 A poll completing while strobe=0 does not alter sh1/sh2; new data is visible only after the next strobe.

Reset
REQ-028 nrst_in low: FSM=IDLE, poll counter=0, jp_clk=0, jp_latch=0, strobe=0, btn1=btn2=0, sh1=sh2=8'hFF, d_out=0, synchronizers=1.
REQ-029 Reset assertion mid-poll aborts immediately; the first poll starts POLL_CYCLES cycles after deassertion.

Structure
REQ-030 Shared package holds JP_REG1=16'h4016, JP_REG2=16'h4017 and the FSM state encoding.
REQ-031 One sub-module jp_shift (8-bit load/shift-with-1-fill register) is instantiated twice.
REQ-032 jp_ctrl lives inside rp2a03; jp_clk/jp_latch connect to NES_JOYPAD_CLK/NES_JOYPAD_LATCH.

Verification (POLL_CYCLES=64, HALF_CYCLES=2)
REQ-033 Pad1 model presses A+Start (pattern 8'b00001001), one full poll, write $4016=1 then 0, eight reads -> d_out[0] = 1,0,0,1,0,0,0,0; ninth read -> 1.
REQ-034 Count jp_latch/jp_clk edges over one poll -> 1 latch pulse of 2 cycles, exactly 7 jp_clk pulses, 2-cycle high and low phases.
REQ-035 strobe=1, pad1 A pressed, three reads of $4016 -> 1,1,1, with no shift.
REQ-036 nrst_in low during CLK_HI of bit 4 -> jp_clk=0 and jp_latch=0 asynchronously; btn1 stays 0; next poll starts 64 cycles after release.
REQ-037 Read $4017 with pad2 pattern 8'b10000000 after strobe -> seven 0 reads, then 1; $4016 reads unaffected; d_out=0 with rd_in=0 at $4016.
REQ-038 Pad pattern changes mid-poll and the poll completes with strobe=0 -> sh1 unchanged until the next strobe write.
